// File: rtl/fpu_vector_sequencer.sv
// fpu_vector_sequencer: walks the A/B operand ROMs, issues A+B, B+A, A-B, B-A to the
// external FPU and presents each result with its operands on a valid/ready stream.
module fpu_vector_sequencer #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_last_addr,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [DATA_WIDTH-1:0] i_rom_a,
    input  logic [DATA_WIDTH-1:0] i_rom_b,
    output logic                  o_add_sub,
    output logic [DATA_WIDTH-1:0] o_32_a,
    output logic [DATA_WIDTH-1:0] o_32_b,
    input  logic [DATA_WIDTH-1:0] i_fpu_s,
    input  logic                  i_fpu_ov,
    input  logic                  i_fpu_un,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic [ADDR_WIDTH-1:0] o_res_addr,
    output logic [1:0]            o_res_op,
    output logic                  o_res_add_sub,
    output logic [DATA_WIDTH-1:0] o_res_a,
    output logic [DATA_WIDTH-1:0] o_res_b,
    output logic [DATA_WIDTH-1:0] o_res_s,
    output logic                  o_res_ov,
    output logic                  o_res_un,
    output logic                  o_busy,
    output logic                  o_done
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [1:0]            op;
        logic                  add_sub;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [DATA_WIDTH-1:0] s;
        logic                  ov;
        logic                  un;
    } res_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            op_q, op_d, next_op;
    logic [DATA_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, a_q, a_d, b_q, b_d;
    logic                  add_sub_q, add_sub_d, res_valid_q, res_valid_d;
    res_t                  res_q, res_d;

    assign next_op = op_q + 2'd1;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        op_d        = op_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        a_d         = a_q;
        b_d         = b_q;
        add_sub_d   = add_sub_q;
        res_valid_d = res_valid_q;
        res_d       = res_q;
        if (i_abort) begin
            state_d     = S_IDLE;
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (i_start) begin
                    addr_d  = '0;
                    op_d    = 2'd0;
                    state_d = S_FETCH;
                end
                S_FETCH: state_d = S_LATCH;
                S_LATCH: begin
                    opa_d     = i_rom_a;
                    opb_d     = i_rom_b;
                    a_d       = i_rom_a;
                    b_d       = i_rom_b;
                    add_sub_d = 1'b0;
                    state_d   = S_ISSUE;
                end
                S_ISSUE: begin
                    res_d       = {addr_q, op_q, add_sub_q, a_q, b_q, i_fpu_s, i_fpu_ov, i_fpu_un};
                    res_valid_d = 1'b1;
                    state_d     = S_WAIT;
                end
                // odd ops swap the operands, ops 2/3 subtract
                S_WAIT: if (i_res_ready) begin
                    res_valid_d = 1'b0;
                    if (op_q != 2'd3) begin
                        op_d      = next_op;
                        add_sub_d = next_op[1];
                        a_d       = next_op[0] ? opb_q : opa_q;
                        b_d       = next_op[0] ? opa_q : opb_q;
                        state_d   = S_ISSUE;
                    end else if (addr_q != i_last_addr) begin
                        addr_d  = addr_q + 1'b1;
                        op_d    = 2'd0;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            op_q        <= 2'd0;
            opa_q       <= '0;
            opb_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            add_sub_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            a_q         <= a_d;
            b_q         <= b_d;
            add_sub_q   <= add_sub_d;
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
        end
    end

    assign o_rom_addr    = addr_q;
    assign o_add_sub     = add_sub_q;
    assign o_32_a        = a_q;
    assign o_32_b        = b_q;
    assign o_res_valid   = res_valid_q;
    assign o_res_addr    = res_q.addr;
    assign o_res_op      = res_q.op;
    assign o_res_add_sub = res_q.add_sub;
    assign o_res_a       = res_q.a;
    assign o_res_b       = res_q.b;
    assign o_res_s       = res_q.s;
    assign o_res_ov      = res_q.ov;
    assign o_res_un      = res_q.un;
    assign o_busy        = state_q != S_IDLE;
    assign o_done        = state_q == S_DONE;
endmodule

// File: tb/tb_fpu_vector_sequencer.sv
// tb_fpu_vector_sequencer: directed runs against registered ROM models and a
// truncating, flush-to-zero single-precision add/sub stand-in for the FPU.
module tb_fpu_vector_sequencer;
    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, add_sub, res_valid, res_ready;
    logic          fpu_ov, fpu_un, res_add_sub, res_ov, res_un, busy, done;
    logic [AW-1:0] last_addr, rom_addr, res_addr;
    logic [DW-1:0] rom_a_q, rom_b_q, a32, b32, fpu_s, res_a, res_b, res_s;
    logic [1:0]    res_op;
    logic [DW-1:0] rom_a [2**AW];
    logic [DW-1:0] rom_b [2**AW];
    logic [DW-1:0] s0, s2;
    logic          ov0;
    int            n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    fpu_vector_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_last_addr(last_addr),
        .o_rom_addr(rom_addr), .i_rom_a(rom_a_q), .i_rom_b(rom_b_q),
        .o_add_sub(add_sub), .o_32_a(a32), .o_32_b(b32),
        .i_fpu_s(fpu_s), .i_fpu_ov(fpu_ov), .i_fpu_un(fpu_un),
        .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_addr(res_addr), .o_res_op(res_op),
        .o_res_add_sub(res_add_sub), .o_res_a(res_a), .o_res_b(res_b), .o_res_s(res_s),
        .o_res_ov(res_ov), .o_res_un(res_un), .o_busy(busy), .o_done(done)
    );

    always @(posedge clk) begin
        rom_a_q <= rom_a[rom_addr];
        rom_b_q <= rom_b[rom_addr];
    end

    function automatic real f2r(input logic [31:0] x);
        return x[30:23] == 8'd0 ? 0.0 : $bitstoreal({x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'b0});
    endfunction

    // returns {s, ov, un}
    function automatic logic [33:0] fpu(input logic sub, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] d;
        logic [31:0] s;
        logic        un;
        int          e;
        d  = $realtobits(sub ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
        e  = int'(d[62:52]) - 896;
        un = 1'b0;
        if (d[62:52] == 11'd0) s = {d[63], 31'b0};
        else if (e <= 0) begin
            s  = {d[63], 31'b0};
            un = 1'b1;
        end else if (e >= 255) s = {d[63], 8'hff, 23'b0};
        else s = {d[63], e[7:0], d[51:29]};
        return {s, s[30:23] == 8'hff, un};
    endfunction

    always_comb {fpu_s, fpu_ov, fpu_un} = fpu(add_sub, a32, b32);

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int last, input bit stall);
        int           ea, eo, beats, done_t, limit;
        bit           held;
        logic [111:0] cur, prev, exp;
        logic [31:0]  x, y;
        logic         sub;
        ea = 0; eo = 0; beats = 0; done_t = -1; held = 0; prev = '0;
        limit = 30 * (last + 1) + 50;
        last_addr = AW'(last);
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int t = 0; t < limit && done_t < 0; t++) begin
            start = (t == 4);
            if (done) done_t = t;
            res_ready = !stall || (t % 3 == 0);
            if (res_valid) begin
                cur = {res_addr, res_op, res_add_sub, res_a, res_b, res_s, res_ov, res_un};
                if (held) chk("hold", cur, prev);
                if (res_ready) begin
                    sub = eo[1];
                    x   = eo[0] ? rom_b[ea] : rom_a[ea];
                    y   = eo[0] ? rom_a[ea] : rom_b[ea];
                    exp = {AW'(ea), 2'(eo), sub, x, y, fpu(sub, x, y)};
                    chk("beat", cur, exp);
                    if (ea == 0 && eo == 0) begin
                        s0  = res_s;
                        ov0 = res_ov;
                    end
                    if (ea == 0 && eo == 2) s2 = res_s;
                    beats++;
                    held = 0;
                    eo = (eo + 1) % 4;
                    if (eo == 0) ea++;
                end else begin
                    held = 1;
                    prev = cur;
                end
            end
            if (done_t < 0) tick;
        end
        start = 1'b0;
        if (done_t < 0) chk("done_timeout", 0, 1);
        chk("beats", beats, 4 * (last + 1));
        if (!stall) chk("done_cycle", done_t, 10 * (last + 1));
        tick;
        chk("done_pulse", {done, busy}, 0);
    endtask

    initial begin
        int found;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0; last_addr = '0;
        s0 = '0; s2 = '0; ov0 = 1'b0;
        for (int i = 0; i < 2**AW; i++) begin
            rom_a[i] = {i[0], 8'd100 + 8'(i[5:0]), 12'(i * 37), 11'h0};
            rom_b[i] = {i[1], 8'd101 + 8'(i[4:0]), 23'(i * 91)};
        end
        #12;
        chk("reset", {rom_addr, add_sub, a32, b32, res_valid, res_addr, res_op, res_add_sub,
                      res_a, res_b, res_s, res_ov, res_un, busy, done}, 0);
        rst_n = 1'b1;
        tick;

        rom_a[0] = 32'h40533333;
        rom_b[0] = 32'hc00ccccd;
        run(0, 0);
        run(3, 1);

        rom_a[0] = 32'h7f7fffff;
        rom_b[0] = 32'h7f7fffff;
        run(0, 0);
        chk("ov_sum", s0, 32'h7f800000);
        chk("ov_flag", ov0, 1);
        chk("sub_zero", s2, 0);

        start = 1'b1; abort = 1'b1;
        tick;
        start = 1'b0; abort = 1'b0;
        chk("abort_idle", busy, 0);

        found = 0;
        last_addr = AW'(3);
        res_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int t = 0; t < 200 && found == 0; t++) begin
            if (res_valid && res_addr == AW'(2) && res_op == 2'd1) begin
                abort = 1'b1;
                found = 1;
            end
            tick;
            abort = 1'b0;
        end
        chk("abort_found", found, 1);
        chk("abort_state", {res_valid, busy, done}, 0);
        tick;
        chk("abort_nodone", {busy, done}, 0);
        run(1, 0);

        last_addr = '0;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        chk("issue_busy", {busy, a32}, {1'b1, 32'h7f7fffff});
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {rom_addr, add_sub, a32, b32, res_valid, res_s, busy, done}, 0);
        #1 rst_n = 1'b1;
        tick;
        chk("post_reset", busy, 0);
        run(0, 0);

        run(2**AW - 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
